// File: rtl/adc_emu_pkg.sv
// Shared types and constants for the serial ADC emulator: FSM states,
// pattern-source selectors and the Galois LFSR step.
package adc_emu_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHIFT   = 2'd2
    } state_t;

    localparam logic [1:0] PAT_CONST = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_LFSR  = 2'd2;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Right-shifting Galois form: the bit falling out of bit 0 feeds the taps.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous pin followed by an edge-detect
// flop; rise_o/fall_o are one-cycle pulses.
module sync_edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/adc_serial_responder.sv
// Serial ADC emulator (responder side of cnv/sck/sdo). Define
// ADC_BUSY_INDICATOR_EN to hold sdo_p low during conversion (busy-indicator mode).
module adc_serial_responder
    import adc_emu_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          T_CONV    = 149,
    parameter int          RAMP_STEP = 1,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
    input  logic              clk210_p,
    input  logic              resetn_p,
    input  logic              cnv_p,
    input  logic              sck_p,
    output logic              sdo_p,
    input  logic [1:0]        pattern_sel_p,
    input  logic [DATA_W-1:0] const_sample_p,
    input  logic              overrun_clr_p,
    output logic              overrun_p,
    output logic              frame_done_p,
    output logic [15:0]       sample_cnt_p
);

    localparam int CNT_W = (T_CONV > 1) ? $clog2(T_CONV) : 1;
    localparam int BIT_W = $clog2(DATA_W);

`ifdef ADC_BUSY_INDICATOR_EN
    localparam logic CONV_SDO = 1'b0;
`else
    localparam logic CONV_SDO = 1'b1;
`endif

    logic cnv_rise, cnv_fall_unused;
    logic sck_fall, sck_rise_unused;

    sync_edge_det u_cnv_sync (
        .clk_i  (clk210_p),
        .rst_ni (resetn_p),
        .d_i    (cnv_p),
        .rise_o (cnv_rise),
        .fall_o (cnv_fall_unused)
    );

    sync_edge_det u_sck_sync (
        .clk_i  (clk210_p),
        .rst_ni (resetn_p),
        .d_i    (sck_p),
        .rise_o (sck_rise_unused),
        .fall_o (sck_fall)
    );

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  conv_cnt_q, conv_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] ramp_q, ramp_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              overrun_q, overrun_d;
    logic              done_q, done_d;
    logic              sdo_q, sdo_d;
    logic [DATA_W-1:0] pattern_val;

    always_comb begin
        case (pattern_sel_p)
            PAT_RAMP: pattern_val = ramp_q;
            PAT_LFSR: pattern_val = lfsr_q[DATA_W-1:0];
            default:  pattern_val = const_sample_p;
        endcase
    end

    always_ff @(posedge clk210_p or negedge resetn_p) begin
        if (!resetn_p) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            conv_cnt_q <= '0;
            bit_cnt_q  <= '0;
            ramp_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            cnt_q      <= '0;
            overrun_q  <= 1'b0;
            done_q     <= 1'b0;
            sdo_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            conv_cnt_q <= conv_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            ramp_q     <= ramp_d;
            lfsr_q     <= lfsr_d;
            cnt_q      <= cnt_d;
            overrun_q  <= overrun_d;
            done_q     <= done_d;
            sdo_q      <= sdo_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        conv_cnt_d = conv_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        ramp_d     = ramp_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        overrun_d  = overrun_q & ~overrun_clr_p;
        done_d     = 1'b0;

        // A cnv rise always starts a fresh capture; outside IDLE it is also an overrun.
        if (cnv_rise) begin
            if (state_q != IDLE) overrun_d = 1'b1;
            shift_d    = pattern_val;
            if (pattern_sel_p == PAT_RAMP) ramp_d = ramp_q + DATA_W'(RAMP_STEP);
            if (pattern_sel_p == PAT_LFSR) lfsr_d = lfsr_step(lfsr_q);
            cnt_d      = cnt_q + 16'd1;
            conv_cnt_d = CNT_W'(T_CONV - 1);
            bit_cnt_d  = '0;
            state_d    = CONVERT;
        end else begin
            case (state_q)
                CONVERT: begin
                    if (conv_cnt_q == '0) state_d = SHIFT;
                    else                  conv_cnt_d = conv_cnt_q - 1'b1;
                end
                SHIFT: begin
                    if (sck_fall) begin
                        if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        // sdo is registered from the next state so it changes together with the state.
        case (state_d)
            SHIFT:   sdo_d = shift_d[DATA_W-1];
            CONVERT: sdo_d = CONV_SDO;
            default: sdo_d = 1'b1;
        endcase
    end

    assign sdo_p        = sdo_q;
    assign overrun_p    = overrun_q;
    assign frame_done_p = done_q;
    assign sample_cnt_p = cnt_q;

endmodule

// File: tb/tb_adc_serial_responder.sv
// Directed bench for adc_serial_responder: master tasks drive cnv/sck and queue
// expected words; a monitor assembles sdo bits and checks them on frame_done_p.
module tb_adc_serial_responder;

    localparam int DATA_W = 16;
    localparam int T_CONV = 149;
`ifdef ADC_BUSY_INDICATOR_EN
    localparam logic CONV_LVL = 1'b0;
`else
    localparam logic CONV_LVL = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        cnv = 1'b0;
    logic        sck = 1'b0;
    logic        sdo;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] const_sample = 16'h0000;
    logic        overrun_clr = 1'b0;
    logic        overrun;
    logic        frame_done;
    logic [15:0] sample_cnt;

    int total = 0;
    int bad = 0;
    int pushes = 0;
    int done_seen = 0;
    int exp_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] mon_sh = '0;
    int          mon_n = 0;

    always #5 clk = ~clk;

    adc_serial_responder #(
        .DATA_W    (DATA_W),
        .T_CONV    (T_CONV),
        .RAMP_STEP (1),
        .LFSR_SEED (32'hACE1_0001)
    ) dut (
        .clk210_p       (clk),
        .resetn_p       (resetn),
        .cnv_p          (cnv),
        .sck_p          (sck),
        .sdo_p          (sdo),
        .pattern_sel_p  (pattern_sel),
        .const_sample_p (const_sample),
        .overrun_clr_p  (overrun_clr),
        .overrun_p      (overrun),
        .frame_done_p   (frame_done),
        .sample_cnt_p   (sample_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: master samples sdo on sck rise; a cnv rise starts a new word.
    always @(posedge sck) begin
        mon_sh <= {mon_sh[14:0], sdo};
        mon_n  <= mon_n + 1;
    end
    always @(posedge cnv) mon_n <= 0;

    always @(negedge clk) begin
        if (frame_done) begin
            done_seen++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL frame_unexpected: got %04h expected none", mon_sh);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                $display("frame %0d: read %04h expected %04h", done_seen, mon_sh, e);
                if (mon_sh !== e) begin
                    bad++;
                    $display("FAIL frame_data: got %04h expected %04h", mon_sh, e);
                end
            end
            check("frame_bits", (mon_n >= 16) ? 32'd1 : 32'd0, 32'd1);
        end
    end

    task automatic cnv_pulse();
        @(negedge clk) cnv = 1'b1;
        repeat (6) @(negedge clk);
        cnv = 1'b0;
    endtask

    task automatic sck_cycles(input int n);
        repeat (n) begin
            @(negedge clk) sck = 1'b1;
            repeat (8) @(negedge clk);
            sck = 1'b0;
            repeat (8) @(negedge clk);
        end
    endtask

    task automatic run_frame(input logic [15:0] exp, input int pre_sck);
        exp_q.push_back(exp);
        pushes++;
        exp_cnt++;
        cnv_pulse();
        sck_cycles(pre_sck);
        repeat (T_CONV + 10) @(negedge clk);
        sck_cycles(16);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        check("reset_sdo", sdo, 1);
        check("reset_overrun", overrun, 0);
        check("reset_done", frame_done, 0);
        check("reset_cnt", sample_cnt, 0);
        resetn = 1'b1;
        repeat (3) @(negedge clk);

        // Const frame, with sck pulses during CONVERT that must not shift.
        pattern_sel = 2'd0;
        const_sample = 16'hA5C3;
        run_frame(16'hA5C3, 3);
        check("const_cnt", sample_cnt, 32'(exp_cnt[15:0]));
        check("const_sdo_idle", sdo, 1);
        check("const_done_count", done_seen, 1);

        // Conversion timing: MSB (0) of 5A5A appears 152 cycles after the pin edge.
        const_sample = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        pushes++;
        exp_cnt++;
        @(negedge clk) cnv = 1'b1;
        for (int n = 1; n <= 152; n++) begin
            @(posedge clk);
            #1;
            if (n == 5) cnv = 1'b0;
            if (n <= 2)        check("tconv_idle", sdo, 1);
            else if (n <= 151) check("tconv_convert", sdo, 32'(CONV_LVL));
            else               check("tconv_msb", sdo, 0);
        end
        repeat (10) @(negedge clk);
        sck_cycles(16);
        repeat (6) @(negedge clk);

        // Ramp from reset value.
        pattern_sel = 2'd1;
        run_frame(16'h0000, 0);
        run_frame(16'h0001, 0);
        run_frame(16'h0002, 0);
        check("ramp_cnt", sample_cnt, 32'(exp_cnt[15:0]));

        // Abort after the 5th sck fall: ramp 3 is discarded, new frame carries 4.
        check("pre_abort_overrun", overrun, 0);
        cnv_pulse();
        exp_cnt++;
        repeat (T_CONV + 10) @(negedge clk);
        sck_cycles(5);
        run_frame(16'h0004, 0);
        check("abort_overrun", overrun, 1);
        check("abort_done_count", done_seen, 6);
        check("abort_cnt", sample_cnt, 32'(exp_cnt[15:0]));

        @(negedge clk) overrun_clr = 1'b1;
        @(negedge clk) overrun_clr = 1'b0;
        check("overrun_clear", overrun, 0);

        // Clear coinciding with a new overrun: set wins.
        cnv_pulse();
        exp_cnt++;
        repeat (20) @(negedge clk);
        exp_q.push_back(16'h0006);
        pushes++;
        exp_cnt++;
        @(negedge clk) cnv = 1'b1;
        @(negedge clk);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("overrun_set_wins", overrun, 1);
        repeat (4) @(negedge clk);
        cnv = 1'b0;
        repeat (T_CONV + 10) @(negedge clk);
        sck_cycles(16);
        repeat (6) @(negedge clk);
        check("overrun_cnt", sample_cnt, 32'(exp_cnt[15:0]));

        // Reset mid-SHIFT, then LFSR frames from the seed.
        pattern_sel = 2'd2;
        cnv_pulse();
        repeat (T_CONV + 10) @(negedge clk);
        sck_cycles(4);
        @(negedge clk) resetn = 1'b0;
        #1;
        check("midreset_sdo", sdo, 1);
        check("midreset_overrun", overrun, 0);
        check("midreset_cnt", sample_cnt, 0);
        check("midreset_done", frame_done, 0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        run_frame(16'h0001, 0);
        run_frame(16'h8003, 0);
        check("lfsr_cnt", sample_cnt, 32'(exp_cnt[15:0]));
        check("end_sdo", sdo, 1);

        check("queue_drained", exp_q.size(), 0);
        check("done_total", done_seen, pushes);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
